fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V instruction fetch stage with 2-entry word FIFO
//
// Keeps the fetch PC and issues word requests to a synchronous instruction
// memory whose data returns one cycle later. Returned words are buffered in a
// 2-entry FIFO that feeds the decoder over a valid/ready handshake. A redirect
// flushes the FIFO and kills the in-flight request. A halt stops fetch until
// reset.
//
// Ports:
//   clk, rst_n                  core clock, asynchronous active-low reset
//   imem_req, imem_addr         fetch request and word-aligned address
//   imem_rdata                  instruction word, one cycle after its request
//   ir, ir_pc, ir_valid         FIFO head to the decoder
//   id_ready                    decoder accepts the head this cycle
//   redirect_valid, redirect_pc taken branch/jump target
//   halt, halted                halt request and HALT state indicator
//   perf_fetched, perf_stall    performance counters (FETCH_PERF_EN only)
//
// Optional feature macro: FETCH_PERF_EN adds the performance counters.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  state_t      r_state;
  // Holds fetch off for the first edge after reset release, so the request
  // output stays low throughout reset.
  logic        r_active;
  logic [31:0] r_pc_f;
  logic        r_inflight;
  logic [31:0] r_inflight_addr;
  logic [31:0] r_fifo_data [2];
  logic [31:0] r_fifo_pc   [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_fetch;
  logic        w_pop;
  logic        w_flush;
  logic        w_push;
  logic [2:0]  w_occ;
  logic        w_issue;

  assign w_fetch = (r_state == S_FETCH);
  assign w_pop   = w_fetch & (r_count != 2'd0) & id_ready;
  assign w_flush = w_fetch & (halt | redirect_valid);
  // A flush kills the response arriving this cycle.
  assign w_push  = r_inflight & ~w_flush;
  // Occupancy after this cycle's pop, counting the word still in flight.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = w_fetch & r_active & ~halt & ~redirect_valid & (w_occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_FETCH;
      r_active        <= 1'b0;
      r_pc_f          <= RESET_PC;
      r_inflight      <= 1'b0;
      r_inflight_addr <= 32'h0;
      r_fifo_data[0]  <= 32'h0;
      r_fifo_data[1]  <= 32'h0;
      r_fifo_pc[0]    <= 32'h0;
      r_fifo_pc[1]    <= 32'h0;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      r_active <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (halt || redirect_valid) begin
            if (halt) begin
              r_state <= S_HALT;
            end else begin
              r_pc_f <= redirect_pc & 32'hFFFF_FFFC;
            end
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
          end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
              r_inflight_addr <= r_pc_f;
              r_pc_f          <= r_pc_f + 32'd4;
            end
            if (w_push) begin
              r_fifo_data[r_wr_ptr] <= imem_rdata;
              r_fifo_pc[r_wr_ptr]   <= r_inflight_addr;
              r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
              r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
              2'b10:   r_count <= r_count + 2'd1;
              2'b01:   r_count <= r_count - 2'd1;
              default: r_count <= r_count;
            endcase
          end
        end
        default: begin
          // HALT is terminal; only rst_n leaves it.
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req  = w_issue;
  assign imem_addr = r_pc_f;
  assign ir        = r_fifo_data[r_rd_ptr];
  assign ir_pc     = r_fifo_pc[r_rd_ptr];
  assign ir_valid  = (r_count != 2'd0);
  assign halted    = (r_state == S_HALT);

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Pops during a redirect or halt cycle still count as accepted transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'h0;
      r_perf_stall   <= 32'h0;
    end else if (w_fetch) begin
      if (w_pop) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (ir_valid && !id_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: word tagged with its address, one cycle after request.
  initial imem_rdata = 32'h0;
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ K;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, apply that cycle's inputs, let outputs settle.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc, input logic h);
    @(posedge clk);
    #1;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check("rst_req",    {31'h0, imem_req}, 32'h0);
    check("rst_addr",   imem_addr, 32'h0);
    check("rst_ir",     ir, 32'h0);
    check("rst_ir_pc",  ir_pc, 32'h0);
    check("rst_valid",  {31'h0, ir_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    // cycle 0..2: first request, data, first valid word
    cyc(1, 0, 0, 0);
    check("c0_req",   {31'h0, imem_req}, 32'h1);
    check("c0_addr",  imem_addr, 32'h0);
    check("c0_valid", {31'h0, ir_valid}, 32'h0);
    cyc(1, 0, 0, 0);
    check("c1_addr",  imem_addr, 32'h4);
    check("c1_valid", {31'h0, ir_valid}, 32'h0);
    cyc(1, 0, 0, 0);
    check("c2_valid", {31'h0, ir_valid}, 32'h1);
    check("c2_pc",    ir_pc, 32'h0);
    check("c2_ir",    ir, K);

    // cycles 3..7: decoder stalls, FIFO fills, requests stop
    cyc(0, 0, 0, 0);
    check("c3_req", {31'h0, imem_req}, 32'h0);
    check("c3_pc",  ir_pc, 32'h4);
    check("c3_ir",  ir, 32'h4 ^ K);
    for (int i = 4; i < 8; i++) begin
      cyc(0, 0, 0, 0);
      check("stall_req",   {31'h0, imem_req}, 32'h0);
      check("stall_valid", {31'h0, ir_valid}, 32'h1);
      check("stall_pc",    ir_pc, 32'h4);
    end

    // cycles 8..10: release, sequence continues without gap or duplicate
    cyc(1, 0, 0, 0);
    check("c8_pc",   ir_pc, 32'h4);
    check("c8_req",  {31'h0, imem_req}, 32'h1);
    check("c8_addr", imem_addr, 32'hC);
    cyc(1, 0, 0, 0);
    check("c9_pc",   ir_pc, 32'h8);
    cyc(1, 0, 0, 0);
    check("c10_pc",  ir_pc, 32'hC);
    check("c10_ir",  ir, 32'hC ^ K);

    // cycle 11: redirect with one buffered and one in flight
    cyc(0, 1, 32'h0000_0103, 0);
    check("redir_req", {31'h0, imem_req}, 32'h0);
    check("redir_pc",  ir_pc, 32'h10);
    cyc(1, 0, 0, 0);
    check("redir1_valid", {31'h0, ir_valid}, 32'h0);
    check("redir1_req",   {31'h0, imem_req}, 32'h1);
    check("redir1_addr",  imem_addr, 32'h100);
    cyc(1, 0, 0, 0);
    check("redir2_valid", {31'h0, ir_valid}, 32'h0);
    check("redir2_addr",  imem_addr, 32'h104);
    cyc(1, 0, 0, 0);
    check("redir3_valid", {31'h0, ir_valid}, 32'h1);
    check("redir3_pc",    ir_pc, 32'h100);
    check("redir3_ir",    ir, 32'hA5A5_0100);
    cyc(1, 0, 0, 0);
    check("redir4_pc",    ir_pc, 32'h104);

    // cycles 16..20: address wrap at the top of memory
    cyc(1, 1, 32'hFFFF_FFFC, 0);
    check("wrap_req", {31'h0, imem_req}, 32'h0);
    cyc(1, 0, 0, 0);
    check("wrap1_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    check("wrap2_addr", imem_addr, 32'h0);
    cyc(1, 0, 0, 0);
    check("wrap3_pc", ir_pc, 32'hFFFF_FFFC);
    check("wrap3_ir", ir, 32'h5A5A_FFFC);
    cyc(1, 0, 0, 0);
    check("wrap4_pc", ir_pc, 32'h0);

    // halt together with redirect: halt wins and persists
    cyc(1, 1, 32'h200, 1);
    check("halt0_req",    {31'h0, imem_req}, 32'h0);
    check("halt0_halted", {31'h0, halted}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, (i % 2) == 1, 32'h300, 0);
      check("halt_halted", {31'h0, halted}, 32'h1);
      check("halt_valid",  {31'h0, ir_valid}, 32'h0);
      check("halt_req",    {31'h0, imem_req}, 32'h0);
    end

    // asynchronous reset mid-cycle
    #1 rst_n = 1'b0;
    #1;
    check("arst_halted", {31'h0, halted}, 32'h0);
    check("arst_addr",   imem_addr, 32'h0);
    check("arst_ir",     ir, 32'h0);
    check("arst_ir_pc",  ir_pc, 32'h0);
    check("arst_valid",  {31'h0, ir_valid}, 32'h0);
    check("arst_req",    {31'h0, imem_req}, 32'h0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1, 0, 0, 0);
    check("re_c0_req",  {31'h0, imem_req}, 32'h1);
    check("re_c0_addr", imem_addr, 32'h0);

`ifdef FETCH_PERF_EN
    cyc(1, 0, 0, 0);
    for (int i = 2; i < 7; i++) cyc(1, 0, 0, 0);
    for (int i = 7; i < 10; i++) cyc(0, 0, 0, 0);
    for (int i = 10; i < 15; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("perf_fetched", perf_fetched, 32'd10);
    check("perf_stall",   perf_stall, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("perf_fetched_rst", perf_fetched, 32'd0);
    check("perf_stall_rst",   perf_stall, 32'd0);
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
